// File: rtl/qfilt_mask_if.sv
// Valid/ready stream bundle used on both sides of qfilt_mask.
// The master drives valid and data, the slave drives ready.
interface qfilt_mask_if #(
  parameter int W = 17
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qfilt_mask.sv
// Multi-select queue filter: passes items whose ctrl tag is set in SEL_MASK and
// folds eot markers of dropped items onto the last passed item. Optional macro
// QFILT_MASK_EMPTY_EN adds an `empty` MSB and emits placeholders for empty sub-queues.
module qfilt_mask #(
  parameter int                      W_DATA   = 16,
  parameter int                      W_CTRL   = 1,
  parameter int                      LVL      = 1,
  parameter int                      FILT_LVL = 1,
  parameter logic [2**W_CTRL-1:0]    SEL_MASK = 2'b01
) (
  input  logic         clk,
  input  logic         rst,
  qfilt_mask_if.slave  din,
  qfilt_mask_if.master dout
);

  logic [LVL-1:0]    x_eot;
  logic [W_CTRL-1:0] x_ctrl;
  logic [W_DATA-1:0] x_data;
  logic              x_sel;

  logic [LVL-1:0]    h_eot_q, h_eot_d;
  logic [W_CTRL-1:0] h_ctrl_q, h_ctrl_d;
  logic [W_DATA-1:0] h_data_q, h_data_d;
  logic              hv_q, hv_d;
  logic              h_term;

  logic              out_valid;
  logic              hs;
  logic              accept_ok;
  logic              take;

`ifdef QFILT_MASK_EMPTY_EN
  logic              empty_q, empty_d;
  logic              x_term;
  assign x_term = &x_eot[FILT_LVL-1:0];
`endif

  assign {x_eot, x_ctrl, x_data} = din.data;
  assign x_sel  = SEL_MASK[x_ctrl];
  assign h_term = &h_eot_q[FILT_LVL-1:0];

  // H is released either when a new selected item proves it is the last one,
  // or on its own once it carries a complete terminating eot.
  always_comb begin
    out_valid = hv_q & ((din.valid & x_sel) | h_term);
    hs        = out_valid & dout.ready;
    if (x_sel) begin
      accept_ok = ~hv_q | hs;
    end else if (x_eot[0]) begin
      accept_ok = ~hv_q | ~out_valid | hs;
    end else begin
      accept_ok = 1'b1;
    end
    take = din.valid & accept_ok & ~rst;
  end

  assign din.ready  = accept_ok & ~rst;
  assign dout.valid = out_valid;
`ifdef QFILT_MASK_EMPTY_EN
  assign dout.data  = {empty_q, h_eot_q, h_ctrl_q, h_data_q};
`else
  assign dout.data  = {h_eot_q, h_ctrl_q, h_data_q};
`endif

  // An eot-bearing drop arriving in the handshake cycle cannot merge into the
  // element already leaving, so it is treated as if the holder were empty.
  always_comb begin
    h_eot_d  = h_eot_q;
    h_ctrl_d = h_ctrl_q;
    h_data_d = h_data_q;
    hv_d     = hv_q;
`ifdef QFILT_MASK_EMPTY_EN
    empty_d  = empty_q;
`endif
    if (hs) begin
      h_eot_d  = '0;
      h_ctrl_d = '0;
      h_data_d = '0;
      hv_d     = 1'b0;
`ifdef QFILT_MASK_EMPTY_EN
      empty_d  = 1'b0;
`endif
    end
    if (take && x_sel) begin
      h_eot_d  = x_eot;
      h_ctrl_d = x_ctrl;
      h_data_d = x_data;
      hv_d     = 1'b1;
`ifdef QFILT_MASK_EMPTY_EN
      empty_d  = 1'b0;
`endif
    end else if (take && x_eot[0]) begin
      if (hv_q && !hs) begin
        h_eot_d = x_eot;
      end
`ifdef QFILT_MASK_EMPTY_EN
      else if (x_term) begin
        h_eot_d  = x_eot;
        h_ctrl_d = '0;
        h_data_d = '0;
        hv_d     = 1'b1;
        empty_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_eot_q  <= '0;
      h_ctrl_q <= '0;
      h_data_q <= '0;
      hv_q     <= 1'b0;
`ifdef QFILT_MASK_EMPTY_EN
      empty_q  <= 1'b0;
`endif
    end else begin
      h_eot_q  <= h_eot_d;
      h_ctrl_q <= h_ctrl_d;
      h_data_q <= h_data_d;
      hv_q     <= hv_d;
`ifdef QFILT_MASK_EMPTY_EN
      empty_q  <= empty_d;
`endif
    end
  end

endmodule

// File: tb/tb_qfilt_mask.sv
// Bench for qfilt_mask: two instances (FILT_LVL=1 and FILT_LVL=2) with a
// 2-bit ctrl, mask 4'b0101 and 2 eot levels, checked against per-instance queues.
module tb_qfilt_mask;

  localparam int          W_DATA = 16;
  localparam int          W_CTRL = 2;
  localparam int          LVL    = 2;
  localparam logic [3:0]  MASK   = 4'b0101;
  localparam int          IW     = LVL + W_CTRL + W_DATA;
`ifdef QFILT_MASK_EMPTY_EN
  localparam int          OW     = IW + 1;
`else
  localparam int          OW     = IW;
`endif

  typedef struct {
    logic          dut_sel;
    logic [1:0]    ctrl;
    logic [1:0]    eot;
    logic [15:0]   data;
    logic          exp_ready;
    logic          exp_valid;
    int            n_push;
    logic [OW-1:0] push0;
    logic [OW-1:0] push1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          active;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          out_ready;
  logic          cur_ready;
  logic          cur_valid;
  logic [OW-1:0] cur_data;

  int            num_checks = 0;
  int            num_fail   = 0;
  logic [OW-1:0] exp_q0[$];
  logic [OW-1:0] exp_q1[$];
  vec_t          vecs[17];

  always #5 clk = ~clk;

  qfilt_mask_if #(.W(IW)) din0 ();
  qfilt_mask_if #(.W(IW)) din1 ();
  qfilt_mask_if #(.W(OW)) dout0 ();
  qfilt_mask_if #(.W(OW)) dout1 ();

  assign din0.valid  = in_valid & (active == 1'b0);
  assign din1.valid  = in_valid & (active == 1'b1);
  assign din0.data   = in_data;
  assign din1.data   = in_data;
  assign dout0.ready = out_ready;
  assign dout1.ready = out_ready;
  assign cur_ready   = active ? din1.ready  : din0.ready;
  assign cur_valid   = active ? dout1.valid : dout0.valid;
  assign cur_data    = active ? dout1.data  : dout0.data;

  qfilt_mask #(.W_DATA(W_DATA), .W_CTRL(W_CTRL), .LVL(LVL), .FILT_LVL(1), .SEL_MASK(MASK))
    dut0 (.clk(clk), .rst(rst), .din(din0), .dout(dout0));

  qfilt_mask #(.W_DATA(W_DATA), .W_CTRL(W_CTRL), .LVL(LVL), .FILT_LVL(2), .SEL_MASK(MASK))
    dut1 (.clk(clk), .rst(rst), .din(din1), .dout(dout1));

  function automatic logic [OW-1:0] word(input logic [1:0] e, input logic [1:0] c,
                                         input logic [15:0] d);
    return OW'({e, c, d});
  endfunction

  function automatic vec_t mk_vec(input logic s, input logic [1:0] c, input logic [1:0] e,
                                  input logic [15:0] d, input logic r, input logic v,
                                  input int n, input logic [OW-1:0] p0, input logic [OW-1:0] p1);
    vec_t t;
    t.dut_sel = s; t.ctrl = c; t.eot = e; t.data = d;
    t.exp_ready = r; t.exp_valid = v; t.n_push = n; t.push0 = p0; t.push1 = p1;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Holds one item on din until accepted; reports ready/valid seen in the first cycle.
  task automatic applyStimulus(input logic s, input logic [1:0] c, input logic [1:0] e,
                               input logic [15:0] d, output logic rdy0, output logic val0);
    int  wait_cnt;
    bit  done;
    active   = s;
    in_data  = {e, c, d};
    in_valid = 1'b1;
    wait_cnt = 0;
    done     = 0;
    rdy0     = 1'b0;
    val0     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (wait_cnt == 0) begin
        rdy0 = cur_ready;
        val0 = cur_valid;
      end
      if (cur_ready) done = 1;
      @(posedge clk); #2;
      wait_cnt++;
      if (!done && wait_cnt > 20) begin
        num_checks++;
        num_fail++;
        $display("[TB] FAIL accept_timeout: got no din.ready, expected ready within 20 cycles");
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Every output handshake must match the oldest expectation for that instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout0.valid && dout0.ready) begin
        if (exp_q0.size() == 0) checkOutput("out0_unexpected", 32'(dout0.data), 32'hFFFF_FFFF);
        else checkOutput("out0_word", 32'(dout0.data), 32'(exp_q0.pop_front()));
      end
      if (dout1.valid && dout1.ready) begin
        if (exp_q1.size() == 0) checkOutput("out1_unexpected", 32'(dout1.data), 32'hFFFF_FFFF);
        else checkOutput("out1_word", 32'(dout1.data), 32'(exp_q1.pop_front()));
      end
    end
  end

  initial begin
    logic          rdy;
    logic          val;
    logic [OW-1:0] ph;
    ph = '0;
`ifdef QFILT_MASK_EMPTY_EN
    ph = {1'b1, 2'b01, 2'b00, 16'h0000};
`endif

    vecs[0]  = mk_vec(0, 2'd0, 2'b00, 16'hA0A0, 1, 0, 0, '0, '0);
    vecs[1]  = mk_vec(0, 2'd1, 2'b00, 16'hB0B0, 1, 0, 0, '0, '0);
    vecs[2]  = mk_vec(0, 2'd2, 2'b00, 16'hC0C0, 1, 1, 1, word(2'b00, 2'd0, 16'hA0A0), '0);
    vecs[3]  = mk_vec(0, 2'd3, 2'b01, 16'hD0D0, 1, 0, 1, word(2'b01, 2'd2, 16'hC0C0), '0);
    vecs[4]  = mk_vec(0, 2'd0, 2'b00, 16'h1111, 1, 1, 0, '0, '0);
    vecs[5]  = mk_vec(0, 2'd2, 2'b00, 16'h2222, 1, 1, 1, word(2'b00, 2'd0, 16'h1111), '0);
    vecs[6]  = mk_vec(0, 2'd0, 2'b00, 16'h3333, 1, 1, 1, word(2'b00, 2'd2, 16'h2222), '0);
    vecs[7]  = mk_vec(0, 2'd2, 2'b01, 16'h4444, 1, 1, 2, word(2'b00, 2'd0, 16'h3333),
                      word(2'b01, 2'd2, 16'h4444));
    vecs[8]  = mk_vec(0, 2'd1, 2'b00, 16'h5555, 1, 1, 0, '0, '0);
    vecs[9]  = mk_vec(0, 2'd1, 2'b00, 16'h6666, 1, 0, 0, '0, '0);
`ifdef QFILT_MASK_EMPTY_EN
    vecs[10] = mk_vec(0, 2'd1, 2'b01, 16'h7777, 1, 0, 1, ph, '0);
`else
    vecs[10] = mk_vec(0, 2'd1, 2'b01, 16'h7777, 1, 0, 0, '0, '0);
`endif
    vecs[11] = mk_vec(1, 2'd0, 2'b00, 16'h8888, 1, 0, 0, '0, '0);
    vecs[12] = mk_vec(1, 2'd1, 2'b01, 16'h9999, 1, 0, 0, '0, '0);
    vecs[13] = mk_vec(1, 2'd3, 2'b11, 16'hAAAA, 1, 0, 1, word(2'b11, 2'd0, 16'h8888), '0);
    vecs[14] = mk_vec(1, 2'd1, 2'b00, 16'hDDDD, 1, 1, 0, '0, '0);
    vecs[15] = mk_vec(1, 2'd0, 2'b11, 16'hBBBB, 1, 0, 1, word(2'b11, 2'd0, 16'hBBBB), '0);
    vecs[16] = mk_vec(1, 2'd1, 2'b00, 16'hEEEE, 1, 1, 0, '0, '0);

    rst = 1'b1; active = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("rst_valid0", 32'(dout0.valid), 0);
    checkOutput("rst_ready0", 32'(din0.ready), 0);
    checkOutput("rst_data0", 32'(dout0.data), 0);
    checkOutput("rst_valid1", 32'(dout1.valid), 0);
    checkOutput("rst_ready1", 32'(din1.ready), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].n_push > 0) begin
        if (vecs[i].dut_sel) exp_q1.push_back(vecs[i].push0); else exp_q0.push_back(vecs[i].push0);
      end
      if (vecs[i].n_push > 1) begin
        if (vecs[i].dut_sel) exp_q1.push_back(vecs[i].push1); else exp_q0.push_back(vecs[i].push1);
      end
      applyStimulus(vecs[i].dut_sel, vecs[i].ctrl, vecs[i].eot, vecs[i].data, rdy, val);
      checkOutput($sformatf("v%0d_ready", i), 32'(rdy), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d_valid", i), 32'(val), 32'(vecs[i].exp_valid));
    end
    repeat (3) @(posedge clk);
    #2;

    // Backpressure: A is held and cannot leave while dout.ready is low.
    out_ready = 1'b1;
    applyStimulus(0, 2'd0, 2'b00, 16'hA001, rdy, val);
    out_ready = 1'b0;
    applyStimulus(0, 2'd1, 2'b00, 16'hB001, rdy, val);
    checkOutput("bp_drop_ready", 32'(rdy), 1);
    exp_q0.push_back(word(2'b00, 2'd0, 16'hA001));
    active = 1'b0; in_data = {2'b00, 2'd2, 16'hC001}; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(cur_valid), 1);
      checkOutput("bp_data", 32'(cur_data), 32'(word(2'b00, 2'd0, 16'hA001)));
      checkOutput("bp_ready", 32'(cur_ready), 0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(cur_ready), 1);
    @(posedge clk); #2;
    in_valid = 1'b0;

    // Stall: C terminated by a merge, eot drops wait, non-eot drops pass.
    out_ready = 1'b0;
    exp_q0.push_back(word(2'b01, 2'd2, 16'hC001));
    applyStimulus(0, 2'd3, 2'b01, 16'hD001, rdy, val);
    checkOutput("stall_merge_ready", 32'(rdy), 1);
    in_data = {2'b01, 2'd1, 16'hE001}; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("stall_eot_ready", 32'(cur_ready), 0);
      checkOutput("stall_valid", 32'(cur_valid), 1);
      @(posedge clk); #2;
    end
    in_data = {2'b00, 2'd1, 16'hF001};
    @(negedge clk);
    checkOutput("stall_noeot_ready", 32'(cur_ready), 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
`ifdef QFILT_MASK_EMPTY_EN
    exp_q0.push_back(ph);
`endif
    applyStimulus(0, 2'd1, 2'b01, 16'hE001, rdy, val);
    checkOutput("stall_after_ready", 32'(rdy), 1);
    checkOutput("stall_after_valid", 32'(val), 0);
    repeat (2) @(posedge clk);
    #2;

    // Reset while A is held: A must vanish.
    applyStimulus(0, 2'd0, 2'b00, 16'hA002, rdy, val);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", 32'(din0.ready), 0);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("mid_rst_valid", 32'(dout0.valid), 0);
    checkOutput("mid_rst_ready2", 32'(din0.ready), 0);
    checkOutput("mid_rst_data", 32'(dout0.data), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    applyStimulus(0, 2'd0, 2'b00, 16'h0123, rdy, val);
    checkOutput("post_rst_valid", 32'(val), 0);
    exp_q0.push_back(word(2'b00, 2'd0, 16'h0123));
    exp_q0.push_back(word(2'b01, 2'd2, 16'h0456));
    applyStimulus(0, 2'd2, 2'b01, 16'h0456, rdy, val);

    for (int k = 0; k < 20; k++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    checkOutput("drain_q0", 32'(exp_q0.size()), 0);
    checkOutput("drain_q1", 32'(exp_q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
